seg_capture: RTL and testbench

Capture-side counterpart to the digit-to-segment encoder: snoops a time-multiplexed, active-low two-digit seven-segment bus (segment lines plus anode enables), filters each digit through a per-digit stability counter, decodes the settled pattern back to a 4-bit value and reports changes over a valid/ready interface. It sits on the display outputs of the lab FPGA for self-check and on the bench as a display monitor.

---
 rtl/seg_pkg.sv | 35 +++
 rtl/seg_decode.sv | 38 +++
 rtl/seg_capture.sv | 114 +++++++++++
 tb/tb_seg_capture.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared types and segment constants for the seven-segment capture block.
// Segment vectors are active-low, bit0 = A ... bit6 = G.
package seg_pkg;

  typedef logic [6:0] seg_t;

  // Decoded view of one committed pattern.
  typedef struct packed {
    logic [3:0] digit;
    logic       blank;
    logic       err;
  } dec_t;

  localparam int NUM_DIGITS = 2;

  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_BLANK = 7'b1111111;

  localparam seg_t SEG_HEX_A = 7'b0001000;
  localparam seg_t SEG_HEX_B = 7'b0000011;
  localparam seg_t SEG_HEX_C = 7'b1000110;
  localparam seg_t SEG_HEX_D = 7'b0100001;
  localparam seg_t SEG_HEX_E = 7'b0000110;
  localparam seg_t SEG_HEX_F = 7'b0001110;

endpackage

// File: rtl/seg_decode.sv
// seg_decode: combinational seven-segment pattern -> {digit, blank, err}.
// Optional macro SEG_HEX_EN adds the A..F letter shapes; without it those
// shapes fall into the error bucket like any other unknown pattern.
import seg_pkg::*;

module seg_decode (
  input  seg_t i_seg,
  output dec_t o_dec
);

  // Table lookup; anything unlisted reports err with digit 0.
  always_comb begin
    o_dec = '{digit: 4'd0, blank: 1'b0, err: 1'b1};
    case (i_seg)
      SEG_0:     o_dec = '{digit: 4'd0, blank: 1'b0, err: 1'b0};
      SEG_1:     o_dec = '{digit: 4'd1, blank: 1'b0, err: 1'b0};
      SEG_2:     o_dec = '{digit: 4'd2, blank: 1'b0, err: 1'b0};
      SEG_3:     o_dec = '{digit: 4'd3, blank: 1'b0, err: 1'b0};
      SEG_4:     o_dec = '{digit: 4'd4, blank: 1'b0, err: 1'b0};
      SEG_5:     o_dec = '{digit: 4'd5, blank: 1'b0, err: 1'b0};
      SEG_6:     o_dec = '{digit: 4'd6, blank: 1'b0, err: 1'b0};
      SEG_7:     o_dec = '{digit: 4'd7, blank: 1'b0, err: 1'b0};
      SEG_8:     o_dec = '{digit: 4'd8, blank: 1'b0, err: 1'b0};
      SEG_9:     o_dec = '{digit: 4'd9, blank: 1'b0, err: 1'b0};
      SEG_BLANK: o_dec = '{digit: 4'd0, blank: 1'b1, err: 1'b0};
`ifdef SEG_HEX_EN
      SEG_HEX_A: o_dec = '{digit: 4'hA, blank: 1'b0, err: 1'b0};
      SEG_HEX_B: o_dec = '{digit: 4'hB, blank: 1'b0, err: 1'b0};
      SEG_HEX_C: o_dec = '{digit: 4'hC, blank: 1'b0, err: 1'b0};
      SEG_HEX_D: o_dec = '{digit: 4'hD, blank: 1'b0, err: 1'b0};
      SEG_HEX_E: o_dec = '{digit: 4'hE, blank: 1'b0, err: 1'b0};
      SEG_HEX_F: o_dec = '{digit: 4'hF, blank: 1'b0, err: 1'b0};
`endif
      default:   o_dec = '{digit: 4'd0, blank: 1'b0, err: 1'b1};
    endcase
  end

endmodule

// File: rtl/seg_capture.sv
// seg_capture: snoops a multiplexed active-low two-digit seven-segment bus,
// debounces each digit with a run-length counter, and reports changed
// digits over valid/ready. Only the newest value per digit is kept.
// Optional macro SEG_HEX_EN (honoured in seg_decode) enables A..F decode.
import seg_pkg::*;

module seg_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] seg,
  input  logic [1:0] anode,
  input  logic       out_ready,
  output logic       out_valid,
  output logic       out_idx,
  output logic [3:0] out_digit,
  output logic       out_blank,
  output logic       out_err,
  output logic       bus_err
);

  localparam int             CW   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]  CMAX = CW'(STABLE_CYCLES);

  seg_t                  r_seg;
  logic [1:0]            r_an;
  logic                  r_bus_err;
  seg_t                  r_last   [NUM_DIGITS];
  logic [CW-1:0]         r_cnt    [NUM_DIGITS];
  seg_t                  r_commit [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] r_pend;

  logic [NUM_DIGITS-1:0] w_qual;
  logic [NUM_DIGITS-1:0] w_same;
  logic [NUM_DIGITS-1:0] w_evt;
  logic [NUM_DIGITS-1:0] w_clr;
  logic [CW-1:0]         w_cnt_nxt [NUM_DIGITS];
  logic                  w_acc;
  seg_t                  w_sel;
  dec_t                  w_dec;

  assign w_acc = out_valid && out_ready;

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
    // Digit d is sampled only when its anode alone is driven low.
    localparam logic [1:0] SEL = ~(2'b01 << d);
    logic w_reach;

    assign w_qual[d]    = (r_an == SEL);
    assign w_same[d]    = (r_seg == r_last[d]);
    assign w_cnt_nxt[d] = !w_same[d]        ? CW'(1) :
                          (r_cnt[d] == CMAX) ? CMAX   : r_cnt[d] + CW'(1);
    // Commit only on the sample that first reaches the threshold; a
    // saturated counter keeps seeing the same pattern and stays quiet.
    assign w_reach      = (w_cnt_nxt[d] == CMAX) && !(w_same[d] && (r_cnt[d] == CMAX));
    assign w_evt[d]     = w_qual[d] && w_reach && (r_seg != r_commit[d]);
    assign w_clr[d]     = w_acc && (out_idx == 1'(d));
  end

  // Register the raw bus once and track the sticky both-anodes-low error.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_seg     <= SEG_BLANK;
      r_an      <= 2'b11;
      r_bus_err <= 1'b0;
    end else begin
      r_seg <= seg;
      r_an  <= anode;
      if (r_an == 2'b00) r_bus_err <= 1'b1;
    end
  end

  // Per-digit stability tracking, commit and pending flags (commit beats accept).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pend <= '0;
      for (int d = 0; d < NUM_DIGITS; d++) begin
        r_last[d]   <= SEG_BLANK;
        r_cnt[d]    <= '0;
        r_commit[d] <= SEG_BLANK;
      end
    end else begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if (w_qual[d]) begin
          r_last[d] <= r_seg;
          r_cnt[d]  <= w_cnt_nxt[d];
        end
        if (w_evt[d]) begin
          r_commit[d] <= r_seg;
          r_pend[d]   <= 1'b1;
        end else if (w_clr[d]) begin
          r_pend[d]   <= 1'b0;
        end
      end
    end
  end

  // Digit 0 wins when both digits are pending.
  assign out_valid = |r_pend;
  assign out_idx   = !r_pend[0] && r_pend[1];
  assign w_sel     = r_commit[out_idx];

  seg_decode u_dec (
    .i_seg (w_sel),
    .o_dec (w_dec)
  );

  assign out_digit = w_dec.digit;
  assign out_blank = w_dec.blank;
  assign out_err   = w_dec.err;
  assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_seg_capture.sv
// tb_seg_capture: directed sequences, a decode vector table and randomized
// bus traffic, all cross-checked every cycle against a run-length model.
import seg_pkg::*;

module tb_seg_capture;

  localparam int S = 4;
`ifdef SEG_HEX_EN
  localparam bit HEX = 1'b1;
`else
  localparam bit HEX = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] seg = 7'h7F;
  logic [1:0] anode = 2'b11;
  logic       out_ready = 1'b0;
  logic       out_valid, out_idx, out_blank, out_err, bus_err;
  logic [3:0] out_digit;

  seg_capture #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .reset_n(reset_n), .seg(seg), .anode(anode),
    .out_ready(out_ready), .out_valid(out_valid), .out_idx(out_idx),
    .out_digit(out_digit), .out_blank(out_blank), .out_err(out_err),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  localparam seg_t TBL [16] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
                                SEG_8, SEG_9, SEG_HEX_A, SEG_HEX_B, SEG_HEX_C,
                                SEG_HEX_D, SEG_HEX_E, SEG_HEX_F};

  function automatic logic [5:0] ref_dec(input seg_t p);
    for (int v = 0; v < 16; v++)
      if (p == TBL[v] && (v < 10 || HEX)) return {4'(v), 1'b0, 1'b0};
    if (p == 7'h7F) return {4'd0, 1'b1, 1'b0};
    return {4'd0, 1'b0, 1'b1};
  endfunction

  seg_t       m_run [2];
  int         m_len [2];
  seg_t       m_comm[2];
  bit         m_pend[2];
  bit         m_buserr;
  seg_t       m_seg_r;
  logic [1:0] m_an_r;

  function automatic bit m_idx();
    return !m_pend[0] && m_pend[1];
  endfunction

  function automatic logic [8:0] m_out();
    bit i;
    i = m_idx();
    return {m_pend[0] | m_pend[1], i, ref_dec(m_comm[i]), m_buserr};
  endfunction

  // The model sees the bus one cycle late, like the real input register.
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int d = 0; d < 2; d++) begin
        m_run[d] = 7'h7F; m_len[d] = 0; m_comm[d] = 7'h7F; m_pend[d] = 0;
      end
      m_buserr = 0; m_seg_r = 7'h7F; m_an_r = 2'b11;
    end else begin
      if ((m_pend[0] | m_pend[1]) && out_ready) m_pend[m_idx()] = 0;
      if (m_an_r == 2'b00) m_buserr = 1;
      for (int d = 0; d < 2; d++) begin
        if (m_an_r == ((d == 0) ? 2'b10 : 2'b01)) begin
          if (m_seg_r == m_run[d]) m_len[d]++;
          else begin m_run[d] = m_seg_r; m_len[d] = 1; end
          if (m_len[d] == S && m_seg_r != m_comm[d]) begin
            m_comm[d] = m_seg_r; m_pend[d] = 1;
          end
        end
      end
      m_seg_r = seg; m_an_r = anode;
    end
  end

  always @(negedge clk)
    if (chk_en)
      chk("model", {out_valid, out_idx, out_digit, out_blank, out_err, bus_err}, m_out());

  // ---------------- stimulus ----------------
  typedef struct {
    seg_t       pat;
    logic [3:0] dig;
    logic       blank;
    logic       err;
  } vec_t;

  vec_t tv [15];
  seg_t pool [7];
  seg_t pf [2];

  initial begin
    int vcnt, first_k, ecnt, got, r;
    logic [3:0] cap_dig;
    logic cap_idx, cap_blank, cap_err;

    reset_n = 1'b0;
    cyc(3);
    reset_n = 1'b1;
    chk_en = 1'b1;
    chk("rst_valid", out_valid, 0);
    chk("rst_idx",   out_idx,   0);
    chk("rst_digit", out_digit, 0);
    chk("rst_blank", out_blank, 1);
    chk("rst_err",   out_err,   0);
    chk("rst_buserr", bus_err,  0);

    // blank bus never raises an event
    seg = 7'h7F; anode = 2'b10; vcnt = 0;
    repeat (20) begin cyc(1); if (out_valid) vcnt++; end
    chk("blank_noevt", vcnt, 0);
    chk("blank_out", out_blank, 1);
    chk("blank_buserr", bus_err, 0);

    // latency of a steady digit 3
    seg = SEG_3; out_ready = 1'b1; vcnt = 0; first_k = 0; cap_idx = 1; cap_dig = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc(1);
      if (out_valid) begin
        vcnt++;
        if (first_k == 0) begin first_k = k; cap_idx = out_idx; cap_dig = out_digit; end
      end
    end
    chk("d3_count", vcnt, 1);
    chk("d3_edge", first_k, 5);
    chk("d3_idx", cap_idx, 0);
    chk("d3_digit", cap_dig, 3);

    // interleaved scan, both digits pending, digit 0 first
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      anode = (i % 2) ? 2'b01 : 2'b10;
      seg   = (i % 2) ? SEG_7 : SEG_5;
      cyc(1);
    end
    anode = 2'b11;
    cyc(2);
    chk("il_valid0", out_valid, 1);
    chk("il_idx0", out_idx, 0);
    chk("il_digit0", out_digit, 5);
    out_ready = 1'b1; cyc(1); out_ready = 1'b0;
    chk("il_valid1", out_valid, 1);
    chk("il_idx1", out_idx, 1);
    chk("il_digit1", out_digit, 7);
    out_ready = 1'b1; cyc(1); out_ready = 1'b0;
    chk("il_drained", out_valid, 0);

    // glitch restarts the run: one event for 8, none for 1
    anode = 2'b10; out_ready = 1'b1; ecnt = 0; cap_dig = 0;
    for (int i = 0; i < 16; i++) begin
      seg = (i == 3) ? SEG_1 : SEG_8;
      cyc(1);
      if (out_valid) begin ecnt++; cap_dig = out_digit; end
    end
    chk("glitch_events", ecnt, 1);
    chk("glitch_digit", cap_dig, 8);

    // letter A: decoded only with the hex option
    seg = SEG_HEX_A; out_ready = 1'b0;
    cyc(8);
    chk("hexA_valid", out_valid, 1);
    chk("hexA_digit", out_digit, HEX ? 10 : 0);
    chk("hexA_err", out_err, HEX ? 0 : 1);
    out_ready = 1'b1; cyc(1); out_ready = 1'b0;

    // both anodes low -> sticky bus error
    anode = 2'b00; cyc(1); anode = 2'b11; cyc(1);
    chk("buserr_set", bus_err, 1);
    cyc(5);
    chk("buserr_sticky", bus_err, 1);

    // reset in the middle of an unaccepted event
    anode = 2'b10; seg = SEG_6; cyc(8);
    chk("prerst_valid", out_valid, 1);
    chk("prerst_digit", out_digit, 6);
    reset_n = 1'b0; cyc(1);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_blank", out_blank, 1);
    chk("midrst_buserr", bus_err, 0);
    reset_n = 1'b1; seg = 7'h7F; vcnt = 0;
    repeat (10) begin cyc(1); if (out_valid) vcnt++; end
    chk("postrst_noevt", vcnt, 0);

    // decode vector table on digit 0
    tv[0]  = '{SEG_0, 4'd0, 1'b0, 1'b0};
    tv[1]  = '{SEG_1, 4'd1, 1'b0, 1'b0};
    tv[2]  = '{SEG_2, 4'd2, 1'b0, 1'b0};
    tv[3]  = '{SEG_3, 4'd3, 1'b0, 1'b0};
    tv[4]  = '{SEG_4, 4'd4, 1'b0, 1'b0};
    tv[5]  = '{SEG_5, 4'd5, 1'b0, 1'b0};
    tv[6]  = '{SEG_6, 4'd6, 1'b0, 1'b0};
    tv[7]  = '{SEG_7, 4'd7, 1'b0, 1'b0};
    tv[8]  = '{SEG_8, 4'd8, 1'b0, 1'b0};
    tv[9]  = '{SEG_9, 4'd9, 1'b0, 1'b0};
    tv[10] = '{SEG_HEX_A, HEX ? 4'hA : 4'd0, 1'b0, !HEX};
    tv[11] = '{SEG_HEX_F, HEX ? 4'hF : 4'd0, 1'b0, !HEX};
    tv[12] = '{7'b0101010, 4'd0, 1'b0, 1'b1};
    tv[13] = '{SEG_BLANK, 4'd0, 1'b1, 1'b0};
    tv[14] = '{SEG_2, 4'd2, 1'b0, 1'b0};
    anode = 2'b10; out_ready = 1'b1;
    for (int t = 0; t < 15; t++) begin
      seg = tv[t].pat; got = 0;
      cap_idx = 1; cap_dig = 0; cap_blank = 0; cap_err = 0;
      for (int k = 0; k < 12; k++) begin
        cyc(1);
        if (out_valid && got == 0) begin
          got = 1; cap_idx = out_idx; cap_dig = out_digit;
          cap_blank = out_blank; cap_err = out_err;
        end
      end
      chk($sformatf("tbl%0d_event", t), got, 1);
      if (got != 0) begin
        chk($sformatf("tbl%0d_dec", t), {cap_idx, cap_dig, cap_blank, cap_err},
            {1'b0, tv[t].dig, tv[t].blank, tv[t].err});
      end
    end

    // randomized traffic against the model
    pool[0] = SEG_0; pool[1] = SEG_1; pool[2] = SEG_4; pool[3] = SEG_9;
    pool[4] = SEG_BLANK; pool[5] = SEG_HEX_C; pool[6] = 7'h2A;
    pf[0] = SEG_4; pf[1] = SEG_9;
    for (int i = 0; i < 3000; i++) begin
      reset_n = (i != 1500);
      r = int'($urandom_range(0, 99));
      anode = (r < 46) ? 2'b10 : (r < 92) ? 2'b01 : (r < 99) ? 2'b11 : 2'b00;
      if ($urandom_range(0, 11) == 0) pf[$urandom_range(0, 1)] = pool[$urandom_range(0, 6)];
      seg = ($urandom_range(0, 24) == 0) ? 7'($urandom) : pf[(anode == 2'b01) ? 1 : 0];
      out_ready = ($urandom_range(0, 2) != 0);
      cyc(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
